// File: rtl/cp0_regfile.sv
// cp0_regfile: MIPS CP0 (SR, Cause, EPC, PRId) with interrupt sync and entry/ERET bookkeeping.
// Define CP0_COUNT_EN to add Count (sel 9) / Compare (sel 11) timer driving IP[15].
module cp0_regfile #(
  parameter logic [31:0] PRID_VALUE = 32'h0000_2295,
  parameter logic [29:0] EPC_RESET  = 30'h0000_0C00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  sel,
  input  logic [31:0] din,
  input  logic        we,
  input  logic [29:0] pc,
  input  logic [5:0]  hwint,
  input  logic        exlset,
  input  logic        exlclr,
  output logic [31:0] dout,
  output logic [29:0] epc,
  output logic        intreq
);
  logic [5:0]  im, ip;
  logic        exl, ie;
  logic [4:0]  exccode;
  logic        ip5_next;
  logic [31:0] dout_tmr;
  logic        wr_sr, wr_epc;
  assign wr_sr  = we && sel == 5'd12;
  assign wr_epc = we && sel == 5'd14;
`ifdef CP0_COUNT_EN
  logic [31:0] count, compare;
  logic        timer_pending, cmp_armed, wr_count, wr_compare;
  assign wr_count   = we && sel == 5'd9;
  assign wr_compare = we && sel == 5'd11;
  // Compare only becomes live once written or once Count wraps, so reset Compare=0 cannot fire early
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      count         <= '0;
      compare       <= '0;
      timer_pending <= 1'b0;
      cmp_armed     <= 1'b0;
    end else begin
      count         <= wr_count ? din : count + 32'd1;
      compare       <= wr_compare ? din : compare;
      cmp_armed     <= cmp_armed | wr_compare | (!wr_count && count == 32'hFFFF_FFFF);
      timer_pending <= wr_compare ? 1'b0 : (timer_pending | (cmp_armed && count == compare));
    end
  assign ip5_next = hwint[5] | timer_pending;
  assign dout_tmr = sel == 5'd9 ? count : sel == 5'd11 ? compare : 32'd0;
`else
  assign ip5_next = hwint[5];
  assign dout_tmr = 32'd0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      im      <= '0;
      ip      <= '0;
      exl     <= 1'b0;
      ie      <= 1'b0;
      exccode <= '0;
      epc     <= EPC_RESET;
    end else begin
      ip      <= {ip5_next, hwint[4:0]};
      exl     <= exlset ? 1'b1 : exlclr ? 1'b0 : wr_sr ? din[1] : exl;
      im      <= wr_sr ? din[15:10] : im;
      ie      <= wr_sr ? din[0] : ie;
      exccode <= exlset ? 5'd0 : exccode;
      epc     <= exlset ? pc : wr_epc ? din[31:2] : epc;
    end
  assign intreq = (|(ip & im)) & ie & ~exl;
  always_comb
    dout = sel == 5'd12 ? {16'd0, im, 8'd0, exl, ie} :
           sel == 5'd13 ? {16'd0, ip, 3'd0, exccode, 2'd0} :
           sel == 5'd14 ? {epc, 2'd0} :
           sel == 5'd15 ? PRID_VALUE : dout_tmr;
endmodule
